window_3x3_linebuf: RTL and testbench
=====================================

// Module: window_3x3_linebuf
// PURPOSE
//  Converts a raster-order 8-bit pixel stream into 3x3 neighbourhood windows.
//  Holds two line buffers plus a 3x3 register window. Sits directly upstream of
//  the sort (median) stage: pixel_out0..8 connect 1:1 to sort.pixel_in0..8.
//  Only full interior windows are emitted; there is no border padding.
// PARAMETERS
//  DATA_W      8    pixel width in bits
//  IMG_WIDTH   640  pixels per line; must be >= 3
//  IMG_HEIGHT  480  lines per frame; must be >= 3
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       synchronous, active-high reset
//  pixel_in     in   DATA_W  input pixel, raster order
//  pixel_valid  in   1       pixel_in accepted this cycle when high
//  sof          in   1       start of frame; qualified by pixel_valid
//  pixel_out0-8 out  DATA_W  window, row-major: 0=(r-2,c-2) .. 8=(r,c)
//  win_valid    out  1       one-cycle pulse; pixel_out0..8 form a new window
// BEHAVIOUR
//  - Reset: col=0, row=0, window regs=0, pixel_out0..8=0, win_valid=0.
//    Line-buffer RAM is not reset; win_valid gating makes stale contents harmless.
//  - Accept: a pixel is accepted on a cycle where pixel_valid=1. There is no
//    backpressure. Cycles with pixel_valid=0 change no state; outputs hold.
//  - Position: when an accept has sof=1, the pixel is at (0,0), whatever the
//    counters hold. Otherwise it takes (row,col) from the counters.
//    After each accept, col increments. At col=IMG_WIDTH-1, col wraps to 0 and
//    row increments. At row=IMG_HEIGHT-1 with col=IMG_WIDTH-1, both wrap to 0.
//  - Line buffers: lb1 holds the previous line and lb0 the line before it.
//    Each holds IMG_WIDTH entries and is addressed by col. On an accept at col c:
//    read top=lb0[c] and mid=lb1[c]; write lb0[c]<=lb1[c] and lb1[c]<=pixel_in.
//    Read-before-write in the same cycle.
//  - Window: on each accept, columns shift left. The new right column is
//    {top, mid, pixel_in}, giving pixel_out2/5/8.
//  - Valid: win_valid=1 on the cycle after an accept at (r,c) with r>=2 and
//    c>=2. It is 0 otherwise, including during line wrap. Windows never
//    straddle two lines.
//  - Latency: 1 cycle, from the accept of (r,c) to the window whose centre is
//    (r-1,c-1).
//  - Windows per frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2).
//  - sof mid-frame: the pixel is treated as (0,0) of a new frame. No window that
//    mixes frames is ever flagged valid, because the first valid window needs
//    rows 0..2 of the new frame.
//  - rst mid-frame: takes priority over pixel_valid that cycle. The first
//    accept after reset is (0,0).
//  - Width: counters are $clog2 of the dimension. Pixels pass through unmodified.
// TESTING
//  All scenarios use IMG_WIDTH=4, IMG_HEIGHT=4, and feed pixel (r,c) = 4r+c+1
//  with sof on the first pixel.
//  1 16 back-to-back accepts -> exactly 4 win_valid pulses. Windows:
//    {1,2,3,5,6,7,9,10,11}, {2,3,4,6,7,8,10,11,12},
//    {5,6,7,9,10,11,13,14,15}, {6,7,8,10,11,12,14,15,16}.
//  2 Same stream with pixel_valid low on alternate cycles -> the same 4 windows.
//    win_valid never held 2 cycles; outputs stable between pulses.
//  3 Frame 1, then frame 2 with values +100 -> frame 2's first window is
//    {101,102,103,105,106,107,109,110,111}. No frame-1 value appears.
//  4 Frame aborted after pixel 7, then sof with values +100 -> no win_valid
//    before the new (2,2). First window as in scenario 3.
//  5 rst pulsed after pixel 10 (1 cycle) -> all outputs read 0 next cycle.
//    A fresh frame then matches scenario 1 exactly.
//  6 Pixels (3,0) and (3,1) accepted -> win_valid stays 0. Pulse resumes on (3,2).

Source files
------------

// File: rtl/window_3x3_linebuf.sv
// Raster pixel stream to 3x3 neighbourhood windows using two line buffers and a
// register window. Only full interior windows are flagged valid.
module window_3x3_linebuf #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pixel_in,
  input  logic              pixel_valid,
  input  logic              sof,
  output logic [DATA_W-1:0] pixel_out0,
  output logic [DATA_W-1:0] pixel_out1,
  output logic [DATA_W-1:0] pixel_out2,
  output logic [DATA_W-1:0] pixel_out3,
  output logic [DATA_W-1:0] pixel_out4,
  output logic [DATA_W-1:0] pixel_out5,
  output logic [DATA_W-1:0] pixel_out6,
  output logic [DATA_W-1:0] pixel_out7,
  output logic [DATA_W-1:0] pixel_out8,
  output logic              win_valid
);

  localparam int unsigned ColW = $clog2(IMG_WIDTH);
  localparam int unsigned RowW = $clog2(IMG_HEIGHT);

  logic [ColW-1:0]   col_q, col_d, cur_col;
  logic [RowW-1:0]   row_q, row_d, cur_row;
  logic [DATA_W-1:0] lb0_mem [IMG_WIDTH];
  logic [DATA_W-1:0] lb1_mem [IMG_WIDTH];
  logic [DATA_W-1:0] top, mid;
  logic [DATA_W-1:0] win_q [9];
  logic [DATA_W-1:0] win_d [9];
  logic              win_valid_q, win_valid_d;

  // sof forces the accepted pixel to (0,0) regardless of the counters
  assign cur_col = sof ? '0 : col_q;
  assign cur_row = sof ? '0 : row_q;
  assign top     = lb0_mem[cur_col];
  assign mid     = lb1_mem[cur_col];

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    win_d       = win_q;
    win_valid_d = 1'b0;
    if (pixel_valid) begin
      if (cur_col == ColW'(IMG_WIDTH - 1)) begin
        col_d = '0;
        row_d = (cur_row == RowW'(IMG_HEIGHT - 1)) ? '0 : cur_row + RowW'(1);
      end else begin
        col_d = cur_col + ColW'(1);
        row_d = cur_row;
      end
      for (int i = 0; i < 3; i++) begin
        win_d[3*i]   = win_q[3*i+1];
        win_d[3*i+1] = win_q[3*i+2];
      end
      win_d[2]    = top;
      win_d[5]    = mid;
      win_d[8]    = pixel_in;
      win_valid_d = (cur_row >= RowW'(2)) && (cur_col >= ColW'(2));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_valid_d;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  // Line-buffer RAM is never reset; reads above happen before this write lands
  always_ff @(posedge clk) begin
    if (pixel_valid && !rst) begin
      lb0_mem[cur_col] <= mid;
      lb1_mem[cur_col] <= pixel_in;
    end
  end

  assign pixel_out0 = win_q[0];
  assign pixel_out1 = win_q[1];
  assign pixel_out2 = win_q[2];
  assign pixel_out3 = win_q[3];
  assign pixel_out4 = win_q[4];
  assign pixel_out5 = win_q[5];
  assign pixel_out6 = win_q[6];
  assign pixel_out7 = win_q[7];
  assign pixel_out8 = win_q[8];
  assign win_valid  = win_valid_q;

endmodule

// File: tb/tb_window_3x3_linebuf.sv
// Self-checking bench for window_3x3_linebuf on a 4x4 image; expected windows come
// from a frame-image model indexed by linear raster position.
module tb_window_3x3_linebuf;

  localparam int W = 4;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] pixel_in = '0;
  logic       pixel_valid = 1'b0;
  logic       sof = 1'b0;
  logic [7:0] po0, po1, po2, po3, po4, po5, po6, po7, po8;
  logic       win_valid;

  window_3x3_linebuf #(
    .DATA_W    (8),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pixel_in   (pixel_in),
    .pixel_valid(pixel_valid),
    .sof        (sof),
    .pixel_out0 (po0),
    .pixel_out1 (po1),
    .pixel_out2 (po2),
    .pixel_out3 (po3),
    .pixel_out4 (po4),
    .pixel_out5 (po5),
    .pixel_out6 (po6),
    .pixel_out7 (po7),
    .pixel_out8 (po8),
    .win_valid  (win_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: the current frame image and the linear raster index of the next pixel
  logic [7:0]  img [H][W];
  int          idx = 0;
  logic        exp_valid = 1'b0;
  logic [71:0] exp_win = '0;
  logic        hold_known = 1'b1;
  int          pulses = 0;

  function automatic logic [71:0] got_win();
    return {po0, po1, po2, po3, po4, po5, po6, po7, po8};
  endfunction

  // One clock of stimulus; afterwards exp_* describe what the DUT must show
  task automatic step(input logic v, input logic s, input logic [7:0] px);
    int r, c;
    pixel_valid = v;
    sof         = s;
    pixel_in    = px;
    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    if (v) begin
      if (s) idx = 0;
      r = idx / W;
      c = idx % W;
      img[r][c] = px;
      hold_known = 1'b0;
      if (r >= 2 && c >= 2) begin
        exp_valid  = 1'b1;
        hold_known = 1'b1;
        exp_win = {img[r-2][c-2], img[r-2][c-1], img[r-2][c],
                   img[r-1][c-2], img[r-1][c-1], img[r-1][c],
                   img[r][c-2],   img[r][c-1],   img[r][c]};
      end
      idx = (idx + 1) % (W * H);
    end
    pixel_valid = 1'b0;
    sof         = 1'b0;
  endtask

  // Reset asserted together with a valid pixel to show reset wins
  task automatic pulse_reset();
    rst         = 1'b1;
    pixel_valid = 1'b1;
    sof         = 1'b0;
    pixel_in    = 8'hAA;
    @(posedge clk);
    #1;
    rst         = 1'b0;
    pixel_valid = 1'b0;
    idx         = 0;
    exp_valid   = 1'b0;
    exp_win     = '0;
    hold_known  = 1'b1;
  endtask

  task automatic test_reset();
    pulse_reset();
    n_checks++;
    if (win_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: got %b want 0", win_valid);
    end
    n_checks++;
    if (got_win() !== 72'h0) begin
      n_fail++;
      $display("FAIL reset_window: got %h want 0", got_win());
    end
  endtask

  task automatic test_back_to_back(input string name, input int base);
    logic [71:0] first_win;
    logic [71:0] last_win;
    pulses = 0;
    first_win = '0;
    last_win = '0;
    for (int p = 0; p < W * H; p++) begin
      step(1'b1, p == 0, 8'(base + p + 1));
      n_checks++;
      if (win_valid !== exp_valid) begin
        n_fail++;
        $display("FAIL %s_valid px%0d: got %b want %b", name, p, win_valid, exp_valid);
      end
      if (exp_valid) begin
        n_checks++;
        if (got_win() !== exp_win) begin
          n_fail++;
          $display("FAIL %s_window px%0d: got %h want %h", name, p, got_win(), exp_win);
        end
      end
      if (win_valid === 1'b1) begin
        if (pulses == 0) first_win = got_win();
        last_win = got_win();
        pulses++;
      end
    end
    n_checks++;
    if (pulses != 4) begin
      n_fail++;
      $display("FAIL %s_pulses: got %0d want 4", name, pulses);
    end
    n_checks++;
    if (first_win !== {8'(base+1), 8'(base+2), 8'(base+3), 8'(base+5), 8'(base+6),
                       8'(base+7), 8'(base+9), 8'(base+10), 8'(base+11)}) begin
      n_fail++;
      $display("FAIL %s_first_window: got %h", name, first_win);
    end
    n_checks++;
    if (last_win !== {8'(base+6), 8'(base+7), 8'(base+8), 8'(base+10), 8'(base+11),
                      8'(base+12), 8'(base+14), 8'(base+15), 8'(base+16)}) begin
      n_fail++;
      $display("FAIL %s_last_window: got %h", name, last_win);
    end
  endtask

  task automatic test_gaps();
    logic prev_valid;
    pulses = 0;
    prev_valid = 1'b0;
    for (int p = 0; p < W * H; p++) begin
      for (int g = 0; g < 2; g++) begin
        step(g == 0, (g == 0) && (p == 0), 8'(p + 1));
        n_checks++;
        if (win_valid !== exp_valid) begin
          n_fail++;
          $display("FAIL gaps_valid px%0d g%0d: got %b want %b", p, g, win_valid, exp_valid);
        end
        n_checks++;
        if (prev_valid && win_valid) begin
          n_fail++;
          $display("FAIL gaps_pulse_width px%0d: got 2-cycle pulse want 1", p);
        end
        if (hold_known) begin
          n_checks++;
          if (got_win() !== exp_win) begin
            n_fail++;
            $display("FAIL gaps_window px%0d g%0d: got %h want %h", p, g, got_win(), exp_win);
          end
        end
        if (win_valid === 1'b1) pulses++;
        prev_valid = win_valid;
      end
    end
    n_checks++;
    if (pulses != 4) begin
      n_fail++;
      $display("FAIL gaps_pulses: got %0d want 4", pulses);
    end
  endtask

  // Aborted frame then sof: no pulse may appear before the new frame's (2,2)
  task automatic test_abort();
    for (int p = 0; p < 7; p++) begin
      step(1'b1, p == 0, 8'(p + 1));
    end
    test_back_to_back("abort", 100);
  endtask

  task automatic test_reset_midframe();
    for (int p = 0; p < 10; p++) begin
      step(1'b1, p == 0, 8'(p + 1));
    end
    pulse_reset();
    n_checks++;
    if (win_valid !== 1'b0 || got_win() !== 72'h0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got v=%b win=%h want 0/0", win_valid, got_win());
    end
    test_back_to_back("after_reset", 0);
  endtask

  task automatic test_random();
    int mid_sof_at;
    for (int f = 0; f < 4; f++) begin
      mid_sof_at = (f == 2) ? int'($urandom_range(3, 12)) : -1;
      for (int p = 0; p < W * H; p++) begin
        while ($urandom_range(0, 9) < 3) begin
          step(1'b0, $urandom_range(0, 1) == 1, 8'($urandom));
          n_checks++;
          if (win_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_idle_valid f%0d: got %b want 0", f, win_valid);
          end
          if (hold_known) begin
            n_checks++;
            if (got_win() !== exp_win) begin
              n_fail++;
              $display("FAIL rand_hold f%0d: got %h want %h", f, got_win(), exp_win);
            end
          end
        end
        step(1'b1, (p == 0) || (p == mid_sof_at), 8'($urandom));
        n_checks++;
        if (win_valid !== exp_valid) begin
          n_fail++;
          $display("FAIL rand_valid f%0d px%0d: got %b want %b", f, p, win_valid, exp_valid);
        end
        if (exp_valid) begin
          n_checks++;
          if (got_win() !== exp_win) begin
            n_fail++;
            $display("FAIL rand_window f%0d px%0d: got %h want %h", f, p, got_win(), exp_win);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back("b2b", 0);
    test_gaps();
    test_back_to_back("frame1", 0);
    test_back_to_back("frame2", 100);
    test_abort();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
